// File: rtl/cbus_pkg.sv
// Shared types and defaults for the register-to-register transfer bus.
package cbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  localparam int DEF_NREG  = 4;
  localparam int DEF_WIDTH = 4;

  // Select field width: enough bits to index NREG registers, never below one.
  function automatic int sel_width(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/cbus_reg.sv
// One bus register: loads d when load is high, cleared asynchronously by reset.
module cbus_reg
  import cbus_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage with load enable and asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/cbus_xfer.sv
// Register file on a common bus with a three-phase (accept, read, write)
// register-to-register transfer engine and an always-available external write port.
module cbus_xfer
  import cbus_pkg::*;
#(
  parameter  int NREG  = DEF_NREG,
  parameter  int WIDTH = DEF_WIDTH,
  localparam int SELW  = sel_width(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ext_we,
  input  logic [SELW-1:0]  ext_sel,
  input  logic [WIDTH-1:0] ext_data,
  input  logic [SELW-1:0]  rd_sel,
  input  logic             xfer_req,
  input  logic [SELW-1:0]  xfer_src,
  input  logic [SELW-1:0]  xfer_dst,
  output logic [WIDTH-1:0] bus_out,
  output logic             xfer_busy,
  output logic             xfer_done
);

  state_t           state;
  state_t           next_state;
  logic [SELW-1:0]  src_q;
  logic [SELW-1:0]  dst_q;
  logic [SELW-1:0]  bus_sel;
  logic [WIDTH-1:0] tmp;
  logic [WIDTH-1:0] reg_q [NREG];

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: a request is only looked at in IDLE, so it is never queued.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (xfer_req) next_state = RD;
      RD:      next_state = WR;
      WR:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Transfer datapath: latch indices on accept, snapshot the source in RD, pulse done after WR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q     <= '0;
      dst_q     <= '0;
      tmp       <= '0;
      xfer_done <= 1'b0;
    end else begin
      xfer_done <= (state == WR);
      if (state == IDLE && xfer_req) begin
        src_q <= xfer_src;
        dst_q <= xfer_dst;
      end
      if (state == RD) begin
        tmp <= bus_out;
      end
    end
  end

  assign xfer_busy = (state != IDLE);

  // Bus source mux: the latched source while a transfer is in flight, rd_sel otherwise;
  // indices past the last register read as zero.
  always_comb begin
    bus_sel = (state == IDLE) ? rd_sel : src_q;
    bus_out = '0;
    for (int i = 0; i < NREG; i++) begin
      if (bus_sel == SELW'(i)) begin
        bus_out = reg_q[i];
      end
    end
  end

  // Per-register write arbitration: the transfer write beats a same-edge external write.
  for (genvar g = 0; g < NREG; g++) begin : g_reg
    logic             xfer_hit;
    logic             ext_hit;
    logic [WIDTH-1:0] wr_data;

    assign xfer_hit = (state == WR) && (dst_q == SELW'(g));
    assign ext_hit  = ext_we && (ext_sel == SELW'(g));
    assign wr_data  = xfer_hit ? tmp : ext_data;

    cbus_reg #(.WIDTH(WIDTH)) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (xfer_hit | ext_hit),
      .d     (wr_data),
      .q     (reg_q[g])
    );
  end

endmodule

// File: tb/tb_cbus_xfer.sv
// Bench for cbus_xfer: directed scenarios on a 4x4 instance, directed plus random
// traffic on a 5x8 instance checked against a cycle-count based transfer model.
module tb_cbus_xfer;
  import cbus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance (4 registers of 4 bits)
  logic       a_rst_n, a_we, a_req, a_busy, a_done;
  logic [1:0] a_sel, a_rd_sel, a_src, a_dst;
  logic [3:0] a_data, a_bus;

  // Larger instance (5 registers of 8 bits, 3-bit selects so indices 5..7 are out of range)
  localparam int B_NREG = 5;
  logic       b_rst_n, b_we, b_req, b_busy, b_done;
  logic [2:0] b_sel, b_rd_sel, b_src, b_dst;
  logic [7:0] b_data, b_bus;

  int n_checks = 0;
  int n_fail   = 0;

  cbus_xfer #(.NREG(DEF_NREG), .WIDTH(DEF_WIDTH)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .ext_we(a_we), .ext_sel(a_sel), .ext_data(a_data),
    .rd_sel(a_rd_sel), .xfer_req(a_req), .xfer_src(a_src), .xfer_dst(a_dst),
    .bus_out(a_bus), .xfer_busy(a_busy), .xfer_done(a_done)
  );

  cbus_xfer #(.NREG(B_NREG), .WIDTH(8)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .ext_we(b_we), .ext_sel(b_sel), .ext_data(b_data),
    .rd_sel(b_rd_sel), .xfer_req(b_req), .xfer_src(b_src), .xfer_dst(b_dst),
    .bus_out(b_bus), .xfer_busy(b_busy), .xfer_done(b_done)
  );

  // Reference model for the larger instance: a transfer accepted at edge number acc
  // reads its source at edge acc+1, writes its destination at acc+2, is busy for the
  // two cycles after acceptance and shows done in the cycle after acc+2.
  logic [7:0] m_reg [8];
  logic [7:0] m_snap;
  logic [2:0] m_src, m_dst;
  bit         m_act;
  int         cyc, acc;

  function automatic logic [7:0] mRead(input logic [2:0] idx);
    return (int'(idx) < B_NREG) ? m_reg[idx] : 8'h00;
  endfunction

  function automatic bit mBusy();
    return m_act && ((cyc - acc) < 2);
  endfunction

  function automatic bit mDone();
    return m_act && ((cyc - acc) == 2);
  endfunction

  function automatic logic [7:0] mBus();
    return mBusy() ? mRead(m_src) : mRead(b_rd_sel);
  endfunction

  task automatic mReset();
    for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
    m_snap = 8'h00;
    m_src  = 3'd0;
    m_dst  = 3'd0;
    m_act  = 1'b0;
  endtask

  task automatic modelEdge(input logic we, input logic [2:0] sel, input logic [7:0] data,
                           input logic req, input logic [2:0] src, input logic [2:0] dst);
    bit         busy_pre = mBusy();
    int         age      = cyc + 1 - acc;
    bit         wr_x     = m_act && (age == 2);
    logic [7:0] snap_new = m_snap;
    if (m_act && age == 1) snap_new = mRead(m_src);
    if (we && int'(sel) < B_NREG && !(wr_x && sel == m_dst)) m_reg[sel] = data;
    if (wr_x && int'(m_dst) < B_NREG) m_reg[m_dst] = m_snap;
    m_snap = snap_new;
    cyc++;
    if (!busy_pre && req) begin
      m_act = 1'b1;
      acc   = cyc;
      m_src = src;
      m_dst = dst;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One edge on the small instance, then strobes drop.
  task automatic driveA(input logic we, input logic [1:0] sel, input logic [3:0] data,
                        input logic req, input logic [1:0] src, input logic [1:0] dst);
    a_we = we; a_sel = sel; a_data = data; a_req = req; a_src = src; a_dst = dst;
    @(posedge clk);
    #1;
    a_we = 1'b0; a_req = 1'b0;
  endtask

  task automatic idleA();
    driveA(1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 2'd0);
  endtask

  task automatic readA(input logic [1:0] idx, input logic [3:0] exp, input string tag);
    a_rd_sel = idx;
    #1;
    checkOutput(tag, 32'(a_bus), 32'(exp));
  endtask

  task automatic checkA(input string tag, input logic busy, input logic done);
    checkOutput({tag, "_busy"}, 32'(a_busy), 32'(busy));
    checkOutput({tag, "_done"}, 32'(a_done), 32'(done));
  endtask

  // One edge on the larger instance, mirrored in the model and checked right after.
  task automatic applyStimulus(input logic we, input logic [2:0] sel, input logic [7:0] data,
                               input logic req, input logic [2:0] src, input logic [2:0] dst,
                               input logic [2:0] rsel);
    b_we = we; b_sel = sel; b_data = data; b_req = req; b_src = src; b_dst = dst;
    b_rd_sel = rsel;
    @(posedge clk);
    modelEdge(we, sel, data, req, src, dst);
    #1;
    checkOutput("b_busy", 32'(b_busy), 32'(mBusy()));
    checkOutput("b_done", 32'(b_done), 32'(mDone()));
    checkOutput("b_bus", 32'(b_bus), 32'(mBus()));
    b_we = 1'b0; b_req = 1'b0;
  endtask

  task automatic idleB();
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, b_rd_sel);
  endtask

  task automatic readB(input logic [2:0] idx, input logic [7:0] exp, input string tag);
    b_rd_sel = idx;
    #1;
    checkOutput(tag, 32'(b_bus), 32'(exp));
  endtask

  task automatic sweepB();
    for (int i = 0; i < B_NREG; i++) readB(3'(i), mRead(3'(i)), "b_sweep");
    readB(3'($urandom_range(5, 7)), 8'h00, "b_sweep_oor");
  endtask

  task automatic runA();
    a_rst_n = 1'b0; a_we = 1'b0; a_sel = 2'd0; a_data = 4'h0;
    a_rd_sel = 2'd0; a_req = 1'b0; a_src = 2'd0; a_dst = 2'd0;
    #12;
    checkA("a_in_reset", 1'b0, 1'b0);
    a_rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) readA(2'(i), 4'h0, "a_reset_rd");
    checkA("a_after_reset", 1'b0, 1'b0);

    // Load then transfer 1 -> 3; rd_sel points elsewhere so the bus proves the source path
    driveA(1'b1, 2'd1, 4'hA, 1'b0, 2'd0, 2'd0);
    readA(2'd1, 4'hA, "a_load_reg1");
    a_rd_sel = 2'd2;
    driveA(1'b0, 2'd0, 4'h0, 1'b1, 2'd1, 2'd3);
    checkA("a_rd", 1'b1, 1'b0);
    checkOutput("a_rd_bus", 32'(a_bus), 32'h0000000A);
    idleA();
    checkA("a_wr", 1'b1, 1'b0);
    checkOutput("a_wr_bus", 32'(a_bus), 32'h0000000A);
    idleA();
    checkA("a_done_cycle", 1'b0, 1'b1);
    readA(2'd3, 4'hA, "a_xfer_reg3");
    idleA();
    checkA("a_after_done", 1'b0, 1'b0);

    // Collision: external write to the destination in the WR cycle loses
    driveA(1'b1, 2'd1, 4'h5, 1'b0, 2'd0, 2'd0);
    driveA(1'b0, 2'd0, 4'h0, 1'b1, 2'd1, 2'd3);
    idleA();
    driveA(1'b1, 2'd3, 4'hF, 1'b0, 2'd0, 2'd0);
    checkA("a_collide_done", 1'b0, 1'b1);
    readA(2'd3, 4'h5, "a_collide_reg3");

    // A request while busy is dropped, not queued
    driveA(1'b1, 2'd1, 4'h9, 1'b0, 2'd0, 2'd0);
    driveA(1'b1, 2'd0, 4'h7, 1'b0, 2'd0, 2'd0);
    driveA(1'b0, 2'd0, 4'h0, 1'b1, 2'd1, 2'd3);
    driveA(1'b0, 2'd0, 4'h0, 1'b1, 2'd0, 2'd2);
    idleA();
    checkA("a_ignore_done", 1'b0, 1'b1);
    idleA();
    checkA("a_ignore_after", 1'b0, 1'b0);
    idleA();
    checkA("a_ignore_after2", 1'b0, 1'b0);
    readA(2'd2, 4'h0, "a_ignore_reg2");
    readA(2'd3, 4'h9, "a_ignore_reg3");

    // Reset during RD aborts the transfer
    driveA(1'b1, 2'd3, 4'h2, 1'b0, 2'd0, 2'd0);
    driveA(1'b0, 2'd0, 4'h0, 1'b1, 2'd1, 2'd3);
    #2;
    a_rst_n = 1'b0;
    #1;
    checkA("a_abort", 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) readA(2'(i), 4'h0, "a_abort_rd");
    idleA();
    checkA("a_abort_e1", 1'b0, 1'b0);
    idleA();
    checkA("a_abort_e2", 1'b0, 1'b0);
    readA(2'd3, 4'h0, "a_abort_reg3");
    a_rst_n = 1'b1;
    driveA(1'b0, 2'd0, 4'h0, 1'b1, 2'd1, 2'd0);
    checkA("a_first_req", 1'b1, 1'b0);
    idleA();
    idleA();
    checkA("a_first_req_done", 1'b0, 1'b1);
  endtask

  task automatic runB();
    cyc = 0; acc = 0;
    mReset();
    b_we = 1'b0; b_sel = 3'd0; b_data = 8'h00; b_rd_sel = 3'd0;
    b_req = 1'b0; b_src = 3'd0; b_dst = 3'd0;
    b_rst_n = 1'b0;
    #1;
    checkOutput("b_rst_busy", 32'(b_busy), 32'h0);
    checkOutput("b_rst_done", 32'(b_done), 32'h0);
    b_rst_n = 1'b1;
    sweepB();

    // Back-to-back: 0 -> 4, then 4 -> 2 requested in the done cycle
    applyStimulus(1'b1, 3'd0, 8'h3C, 1'b0, 3'd0, 3'd0, 3'd0);
    applyStimulus(1'b1, 3'd4, 8'h11, 1'b0, 3'd0, 3'd0, 3'd1);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 3'd4, 3'd1);
    idleB();
    idleB();
    checkOutput("b_first_done", 32'(b_done), 32'h1);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 3'd2, 3'd1);
    checkOutput("b_b2b_busy", 32'(b_busy), 32'h1);
    idleB();
    idleB();
    checkOutput("b_b2b_done", 32'(b_done), 32'h1);
    readB(3'd2, 8'h3C, "b_b2b_reg2");

    // Out-of-range source reads zero; out-of-range write is ignored
    applyStimulus(1'b1, 3'd1, 8'h77, 1'b0, 3'd0, 3'd0, 3'd0);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 3'd1, 3'd0);
    idleB();
    idleB();
    checkOutput("b_oor_done", 32'(b_done), 32'h1);
    readB(3'd1, 8'h00, "b_oor_src_reg1");
    applyStimulus(1'b1, 3'd6, 8'hFF, 1'b0, 3'd0, 3'd0, 3'd6);
    readB(3'd6, 8'h00, "b_oor_write");

    // Random traffic with occasional asynchronous reset pulses
    repeat (400) begin
      if ($urandom_range(0, 99) == 0) begin
        b_rst_n = 1'b0;
        #1;
        mReset();
        checkOutput("b_rnd_rst_busy", 32'(b_busy), 32'h0);
        checkOutput("b_rnd_rst_done", 32'(b_done), 32'h0);
        b_rst_n = 1'b1;
      end
      applyStimulus($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), 8'($urandom),
                    $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      if (!mBusy() && $urandom_range(0, 9) == 0) sweepB();
    end
  endtask

  // Main sequence: small instance first, then the larger one, then the summary.
  initial begin
    b_rst_n = 1'b0;
    b_we = 1'b0; b_sel = 3'd0; b_data = 8'h00; b_rd_sel = 3'd0;
    b_req = 1'b0; b_src = 3'd0; b_dst = 3'd0;
    runA();
    runB();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
